// File: rtl/mem_port_arbiter_if.sv
// Request/grant and memory-port bundle between the per-port controllers,
// the shared-buffer arbiter and the SRAM wrapper.
interface mem_port_arbiter_if #(
  parameter int N      = 4,
  parameter int ADDR_W = 10,
  parameter int DATA_W = 64,
  parameter int IDX_W  = $clog2(N)
);
  logic [N-1:0]        req_i;
  logic [N-1:0]        we_i;
  logic [N*ADDR_W-1:0] addr_i;
  logic [N*DATA_W-1:0] wdata_i;
  logic [N-1:0]        gnt_o;
  logic                mem_req_o;
  logic                mem_we_o;
  logic [ADDR_W-1:0]   mem_addr_o;
  logic [DATA_W-1:0]   mem_wdata_o;
  logic                mem_rvalid_i;
  logic [DATA_W-1:0]   mem_rdata_i;
  logic [N-1:0]        rvalid_o;
  logic [DATA_W-1:0]   rdata_o;
  logic [IDX_W-1:0]    gnt_idx_o;
  logic                rsp_err_o;

  modport slave (
    input  req_i, we_i, addr_i, wdata_i, mem_rvalid_i, mem_rdata_i,
    output gnt_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
           rvalid_o, rdata_o, gnt_idx_o, rsp_err_o
  );

  modport master (
    output req_i, we_i, addr_i, wdata_i, mem_rvalid_i, mem_rdata_i,
    input  gnt_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
           rvalid_o, rdata_o, gnt_idx_o, rsp_err_o
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// N-to-1 arbiter for the single-ported shared packet buffer: round robin or
// fixed TDM slots, with a tag pipeline steering read data back to its port.
module mem_port_arbiter #(
  parameter int N      = 4,
  parameter int ADDR_W = 10,
  parameter int DATA_W = 64,
  parameter int RD_LAT = 1,
  parameter int TDM    = 0,
  parameter int IDX_W  = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_port_arbiter_if.slave bus
);

  localparam int               CW   = IDX_W + 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [IDX_W-1:0]  slot_q, slot_d;
  logic [IDX_W-1:0]  win_idx;
  logic              win_vld;
  logic              rd_issue;
  logic [CW-1:0]     cand;
  logic [RD_LAT-1:0] tag_vld_q;
  logic [IDX_W-1:0]  tag_idx_q [RD_LAT];
  logic              err_q, err_d;
  logic              last_vld;
  logic [IDX_W-1:0]  last_idx;

  // Scan from the highest offset down so the closest requester to ptr wins;
  // the wrap is an explicit subtract so non-power-of-two N never indexes N.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    cand    = '0;
    if (TDM != 0) begin
      win_vld = bus.req_i[slot_q];
      win_idx = win_vld ? slot_q : '0;
    end else begin
      for (int k = N - 1; k >= 0; k--) begin
        cand = {1'b0, ptr_q} + CW'(k);
        if (cand >= CW'(N)) cand = cand - CW'(N);
        if (bus.req_i[cand[IDX_W-1:0]]) begin
          win_vld = 1'b1;
          win_idx = cand[IDX_W-1:0];
        end
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (win_vld) ptr_d = (win_idx == LAST) ? '0 : win_idx + 1'b1;
    slot_d = (slot_q == LAST) ? '0 : slot_q + 1'b1;
  end

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_port
      assign bus.gnt_o[gi]    = win_vld && (win_idx == IDX_W'(gi));
      assign bus.rvalid_o[gi] = bus.mem_rvalid_i && last_vld && (last_idx == IDX_W'(gi));
    end
  endgenerate

  assign rd_issue        = win_vld & ~bus.we_i[win_idx];
  assign bus.mem_req_o   = win_vld;
  assign bus.mem_we_o    = win_vld & bus.we_i[win_idx];
  assign bus.mem_addr_o  = win_vld ? bus.addr_i[win_idx*ADDR_W +: ADDR_W] : '0;
  assign bus.mem_wdata_o = win_vld ? bus.wdata_i[win_idx*DATA_W +: DATA_W] : '0;
  assign bus.gnt_idx_o   = win_idx;

  assign last_vld      = tag_vld_q[RD_LAT-1];
  assign last_idx      = tag_idx_q[RD_LAT-1];
  assign bus.rdata_o   = bus.mem_rdata_i;
  assign bus.rsp_err_o = err_q;

  // Data without a tag, or a tag without data, is a protocol error.
  assign err_d = bus.mem_rvalid_i ^ last_vld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q     <= '0;
      slot_q    <= '0;
      err_q     <= 1'b0;
      tag_vld_q <= '0;
      for (int i = 0; i < RD_LAT; i++) tag_idx_q[i] <= '0;
    end else begin
      ptr_q        <= ptr_d;
      slot_q       <= slot_d;
      err_q        <= err_d;
      tag_vld_q[0] <= rd_issue;
      tag_idx_q[0] <= rd_issue ? win_idx : '0;
      for (int i = 1; i < RD_LAT; i++) begin
        tag_vld_q[i] <= tag_vld_q[i-1];
        tag_idx_q[i] <= tag_idx_q[i-1];
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: vector table, corner-case sequences on three
// parameterisations, and a randomized run against a reference model.
module tb_mem_port_arbiter;
  localparam int AW = 8;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter_if #(.N(4), .ADDR_W(AW), .DATA_W(DW)) bus0 ();
  mem_port_arbiter_if #(.N(3), .ADDR_W(AW), .DATA_W(DW)) bus1 ();
  mem_port_arbiter_if #(.N(4), .ADDR_W(AW), .DATA_W(DW)) bus2 ();

  mem_port_arbiter #(.N(4), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(3), .TDM(0)) u_rr4 (
    .clk(clk), .rst_n(rst_n), .bus(bus0));
  mem_port_arbiter #(.N(3), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(1), .TDM(0)) u_rr3 (
    .clk(clk), .rst_n(rst_n), .bus(bus1));
  mem_port_arbiter #(.N(4), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(1), .TDM(1)) u_tdm4 (
    .clk(clk), .rst_n(rst_n), .bus(bus2));

  typedef struct {
    bit         rst_before;
    logic [3:0] req;
    logic [3:0] we;
    logic [3:0] exp_gnt;
    logic [1:0] exp_idx;
    logic       exp_we;
  } vec_t;

  vec_t vt [14];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [AW-1:0] addr_of(input int v, input int p);
    return AW'(v * 16 + p);
  endfunction

  function automatic logic [DW-1:0] wdata_of(input int v, input int p);
    return DW'(16'hA000 + v * 16 + p);
  endfunction

  task automatic idle_all();
    bus0.req_i = '0; bus0.we_i = '0; bus0.addr_i = '0; bus0.wdata_i = '0;
    bus0.mem_rvalid_i = 1'b0; bus0.mem_rdata_i = '0;
    bus1.req_i = '0; bus1.we_i = '0; bus1.addr_i = '0; bus1.wdata_i = '0;
    bus1.mem_rvalid_i = 1'b0; bus1.mem_rdata_i = '0;
    bus2.req_i = '0; bus2.we_i = '0; bus2.addr_i = '0; bus2.wdata_i = '0;
    bus2.mem_rvalid_i = 1'b0; bus2.mem_rdata_i = '0;
  endtask

  // Ends at posedge+1 with reset released: the current cycle is cycle 0.
  task automatic do_reset();
    idle_all();
    @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Randomized-run model state
  bit          m_pend [4];
  bit          m_we   [4];
  logic [AW-1:0] m_addr [4];
  logic [DW-1:0] m_data [4];
  bit          m_sv   [16];
  int          m_sp   [16];

  initial begin
    vt[0]  = '{1'b1, 4'b0100, 4'b0100, 4'b0100, 2'd2, 1'b1};
    vt[1]  = '{1'b0, 4'b0100, 4'b0100, 4'b0100, 2'd2, 1'b1};
    vt[2]  = '{1'b0, 4'b0100, 4'b0100, 4'b0100, 2'd2, 1'b1};
    vt[3]  = '{1'b0, 4'b0100, 4'b0100, 4'b0100, 2'd2, 1'b1};
    vt[4]  = '{1'b0, 4'b0100, 4'b0100, 4'b0100, 2'd2, 1'b1};
    vt[5]  = '{1'b1, 4'b1111, 4'b1010, 4'b0001, 2'd0, 1'b0};
    vt[6]  = '{1'b0, 4'b1111, 4'b1010, 4'b0010, 2'd1, 1'b1};
    vt[7]  = '{1'b0, 4'b1111, 4'b1010, 4'b0100, 2'd2, 1'b0};
    vt[8]  = '{1'b0, 4'b1111, 4'b1010, 4'b1000, 2'd3, 1'b1};
    vt[9]  = '{1'b0, 4'b1111, 4'b1010, 4'b0001, 2'd0, 1'b0};
    vt[10] = '{1'b0, 4'b1111, 4'b1010, 4'b0010, 2'd1, 1'b1};
    vt[11] = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0};
    vt[12] = '{1'b0, 4'b1001, 4'b0001, 4'b1000, 2'd3, 1'b0};
    vt[13] = '{1'b0, 4'b1001, 4'b0001, 4'b0001, 2'd0, 1'b1};

    idle_all();
    do_reset();

    // Reset state
    @(negedge clk);
    check("rst_gnt", bus0.gnt_o, 0);
    check("rst_mem_req", bus0.mem_req_o, 0);
    check("rst_gnt_idx", bus0.gnt_idx_o, 0);
    check("rst_rsp_err", bus0.rsp_err_o, 0);
    check("rst_rvalid", bus0.rvalid_o, 0);
    check("rst_addr", bus0.mem_addr_o, 0);
    tick();

    // Vector table: single requester, full-load round robin, pointer hold
    for (int v = 0; v < 14; v++) begin
      if (vt[v].rst_before) do_reset();
      bus0.req_i = vt[v].req;
      bus0.we_i  = vt[v].we;
      for (int p = 0; p < 4; p++) begin
        bus0.addr_i[p*AW +: AW]  = addr_of(v, p);
        bus0.wdata_i[p*DW +: DW] = wdata_of(v, p);
      end
      @(negedge clk);
      check($sformatf("vec%0d_gnt", v), bus0.gnt_o, vt[v].exp_gnt);
      check($sformatf("vec%0d_idx", v), bus0.gnt_idx_o, vt[v].exp_idx);
      check($sformatf("vec%0d_mem_req", v), bus0.mem_req_o, |vt[v].exp_gnt);
      check($sformatf("vec%0d_mem_we", v), bus0.mem_we_o, vt[v].exp_we);
      check($sformatf("vec%0d_addr", v), bus0.mem_addr_o,
            (vt[v].exp_gnt != 0) ? addr_of(v, int'(vt[v].exp_idx)) : '0);
      check($sformatf("vec%0d_wdata", v), bus0.mem_wdata_o,
            (vt[v].exp_gnt != 0) ? wdata_of(v, int'(vt[v].exp_idx)) : '0);
      $display("vec %0d req=%b gnt=%b idx=%0d we=%b addr=%0h", v, bus0.req_i,
               bus0.gnt_o, bus0.gnt_idx_o, bus0.mem_we_o, bus0.mem_addr_o);
      tick();
    end

    // Read routing with RD_LAT=3: ports 3,0,2 then returns A,B,C
    do_reset();
    begin
      logic [3:0] rd_ports [3];
      logic [DW-1:0] rd_data [3];
      rd_ports[0] = 4'b1000; rd_ports[1] = 4'b0001; rd_ports[2] = 4'b0100;
      rd_data[0] = 16'h000A; rd_data[1] = 16'h000B; rd_data[2] = 16'h000C;
      for (int c = 0; c < 3; c++) begin
        bus0.req_i = rd_ports[c];
        bus0.we_i  = 4'b0000;
        @(negedge clk);
        check($sformatf("rd_gnt%0d", c), bus0.gnt_o, rd_ports[c]);
        check($sformatf("rd_we%0d", c), bus0.mem_we_o, 0);
        tick();
      end
      bus0.req_i = '0;
      for (int c = 0; c < 3; c++) begin
        bus0.mem_rvalid_i = 1'b1;
        bus0.mem_rdata_i  = rd_data[c];
        @(negedge clk);
        check($sformatf("ret_rvalid%0d", c), bus0.rvalid_o, rd_ports[c]);
        check($sformatf("ret_rdata%0d", c), bus0.rdata_o, rd_data[c]);
        check($sformatf("ret_err%0d", c), bus0.rsp_err_o, 0);
        $display("return %0d rvalid=%b rdata=%0h", c, bus0.rvalid_o, bus0.rdata_o);
        tick();
      end
      bus0.mem_rvalid_i = 1'b0;
      @(negedge clk);
      check("ret_tail_rvalid", bus0.rvalid_o, 0);
      check("ret_tail_err", bus0.rsp_err_o, 0);
      tick();
    end

    // Spurious read data: single-cycle error pulse, nothing returned
    bus0.mem_rvalid_i = 1'b1;
    bus0.mem_rdata_i  = 16'hDEAD;
    @(negedge clk);
    check("spur_rvalid", bus0.rvalid_o, 0);
    check("spur_err_early", bus0.rsp_err_o, 0);
    tick();
    bus0.mem_rvalid_i = 1'b0;
    @(negedge clk);
    check("spur_err_pulse", bus0.rsp_err_o, 1);
    tick();
    @(negedge clk);
    check("spur_err_clear", bus0.rsp_err_o, 0);
    tick();

    // Missing read data: tag expires, error pulse one cycle later
    bus0.req_i = 4'b0010; bus0.we_i = 4'b0000;
    tick();
    bus0.req_i = '0;
    tick(); tick();
    @(negedge clk);
    check("miss_rvalid", bus0.rvalid_o, 0);
    tick();
    @(negedge clk);
    check("miss_err_pulse", bus0.rsp_err_o, 1);
    tick();

    // Reset with two reads in flight: they are forgotten
    bus0.req_i = 4'b0001; bus0.we_i = 4'b0000;
    tick();
    bus0.req_i = 4'b0010;
    tick();
    do_reset();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check($sformatf("flush_rvalid%0d", c), bus0.rvalid_o, 0);
      check($sformatf("flush_err%0d", c), bus0.rsp_err_o, 0);
      tick();
    end
    bus0.mem_rvalid_i = 1'b1;
    @(negedge clk);
    check("late_rvalid", bus0.rvalid_o, 0);
    tick();
    bus0.mem_rvalid_i = 1'b0;
    @(negedge clk);
    check("late_err", bus0.rsp_err_o, 1);
    tick();

    // N=3 wrap: ports 0 and 2, then port 1 joins
    do_reset();
    begin
      logic [2:0] exp3 [7];
      exp3[0] = 3'b001; exp3[1] = 3'b100; exp3[2] = 3'b001; exp3[3] = 3'b100;
      exp3[4] = 3'b001; exp3[5] = 3'b010; exp3[6] = 3'b100;
      bus1.we_i = 3'b111;
      for (int p = 0; p < 3; p++) bus1.addr_i[p*AW +: AW] = addr_of(7, p);
      for (int c = 0; c < 7; c++) begin
        bus1.req_i = (c < 4) ? 3'b101 : 3'b111;
        @(negedge clk);
        check($sformatf("n3_gnt%0d", c), bus1.gnt_o, exp3[c]);
        check($sformatf("n3_addr%0d", c), bus1.mem_addr_o,
              addr_of(7, (exp3[c] == 3'b001) ? 0 : (exp3[c] == 3'b010) ? 1 : 2));
        $display("n3 cycle %0d gnt=%b idx=%0d", c, bus1.gnt_o, bus1.gnt_idx_o);
        tick();
      end
      bus1.req_i = '0;
    end

    // TDM: only port 1 requests, granted in cycles 1,5,9
    do_reset();
    bus2.req_i = 4'b0010; bus2.we_i = 4'b0010;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      check($sformatf("tdm_gnt%0d", c), bus2.gnt_o, (c % 4 == 1) ? 4'b0010 : 4'b0000);
      check($sformatf("tdm_req%0d", c), bus2.mem_req_o, (c % 4 == 1) ? 1 : 0);
      if (c % 4 == 1) $display("tdm cycle %0d gnt=%b", c, bus2.gnt_o);
      tick();
    end
    bus2.req_i = '0;

    // Randomized run against the reference model (N=4, RD_LAT=3)
    do_reset();
    begin
      int ptr;
      bit err_exp;
      ptr = 0;
      err_exp = 1'b0;
      for (int i = 0; i < 4; i++) m_pend[i] = 1'b0;
      for (int i = 0; i < 16; i++) begin m_sv[i] = 1'b0; m_sp[i] = 0; end
      for (int t = 0; t < 400; t++) begin
        int w;
        bit base, mv;
        logic [DW-1:0] rd;
        for (int p = 0; p < 4; p++) begin
          if (!m_pend[p] && $urandom_range(0, 2) != 0) begin
            m_pend[p] = 1'b1;
            m_we[p]   = 1'($urandom_range(0, 1));
            m_addr[p] = AW'($urandom);
            m_data[p] = DW'($urandom);
          end
          bus0.req_i[p] = m_pend[p];
          bus0.we_i[p]  = m_we[p];
          bus0.addr_i[p*AW +: AW]  = m_addr[p];
          bus0.wdata_i[p*DW +: DW] = m_data[p];
        end
        base = m_sv[t % 16];
        mv = base;
        if ($urandom_range(0, 19) == 0) mv = !mv;
        rd = DW'($urandom);
        bus0.mem_rvalid_i = mv;
        bus0.mem_rdata_i  = rd;
        w = -1;
        for (int k = 0; k < 4; k++)
          if (w < 0 && m_pend[(ptr + k) % 4]) w = (ptr + k) % 4;
        @(negedge clk);
        check("rnd_gnt", bus0.gnt_o, (w >= 0) ? (64'd1 << w) : 64'd0);
        check("rnd_idx", bus0.gnt_idx_o, (w >= 0) ? w : 0);
        check("rnd_mem_req", bus0.mem_req_o, (w >= 0) ? 1 : 0);
        check("rnd_mem_we", bus0.mem_we_o, (w >= 0) ? m_we[w] : 0);
        check("rnd_addr", bus0.mem_addr_o, (w >= 0) ? m_addr[w] : '0);
        check("rnd_wdata", bus0.mem_wdata_o, (w >= 0) ? m_data[w] : '0);
        check("rnd_rvalid", bus0.rvalid_o, (mv && base) ? (64'd1 << m_sp[t % 16]) : 64'd0);
        if (mv && base) check("rnd_rdata", bus0.rdata_o, rd);
        check("rnd_err", bus0.rsp_err_o, err_exp);
        err_exp = (mv != base);
        m_sv[t % 16] = 1'b0;
        if (w >= 0) begin
          if (!m_we[w]) begin
            m_sv[(t + 3) % 16] = 1'b1;
            m_sp[(t + 3) % 16] = w;
          end
          $display("rnd t=%0d port=%0d %s addr=%0h", t, w, m_we[w] ? "wr" : "rd", m_addr[w]);
          ptr = (w + 1) % 4;
          m_pend[w] = 1'b0;
        end
        tick();
      end
    end

    idle_all();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Parametrised N-to-1 arbiter for the switch's single-ported shared packet buffer. Per-port write and read controllers issue requests with a request/grant handshake. The arbiter selects one request per cycle, by work-conserving round robin or fixed TDM slots, and drives the memory port. Read data returns after a fixed memory latency and is steered back to the issuing port through a tag pipeline, with no per-port polling slots. It sits between the per-port memory controllers and the buffer SRAM wrapper.

## Interface
Parameters:
- N, 4, number of requesting ports; legal values are N ≥ 2, and N need not be a power of two
- ADDR_W, 10, block address width
- DATA_W, 64, block data width
- RD_LAT, 1, memory read latency in cycles from the accepted read to mem_rvalid_i; legal range 1..8
- TDM, 0, arbitration mode: 0 = work-conserving round robin, 1 = fixed time slots
- IDX_W, $clog2(N), port index width (derived)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- req_i  in  N  per-port request; held until granted
- we_i  in  N  per-port request type: 1 = write, 0 = read
- addr_i  in  N×ADDR_W  per-port address
- wdata_i  in  N×DATA_W  per-port write data
- gnt_o  out  N  one-hot grant, combinational, same cycle as the request
- mem_req_o  out  1  memory access strobe
- mem_we_o  out  1  memory write enable (valid when mem_req_o = 1)
- mem_addr_o  out  ADDR_W  memory address
- mem_wdata_o  out  DATA_W  memory write data
- mem_rvalid_i  in  1  read data valid from memory
- mem_rdata_i  in  DATA_W  read data from memory
- rvalid_o  out  N  one-hot read-return valid
- rdata_o  out  DATA_W  read data, broadcast to all ports; qualified by rvalid_o
- gnt_idx_o  out  IDX_W  index of the current winner; 0 when there is no grant
- rsp_err_o  out  1  one-cycle pulse on a read-response/tag mismatch

## Operation
- **Handshake.** A port asserts req_i with we_i, addr_i and wdata_i stable. The transfer completes in the cycle where req_i & gnt_o = 1. The port may then drop the request or present the next one in the following cycle.
- **Round robin (TDM=0).**
  - The search starts at ptr and proceeds ptr, ptr+1, … wrapping at N−1→0; the first asserted req_i wins.
  - On a grant, ptr ← winner+1 mod N. With no grant, ptr holds.
  - The modulo is explicit: an index of N−1 wraps to 0 and must never reach N.
  - Guarantee: each requesting port is granted within N cycles.
- **TDM (TDM=1).**
  - slot advances 0..N−1 and wraps, every cycle, unconditionally.
  - Only port slot can be granted, and only if req_i[slot] = 1. The cycle is idle otherwise.
- **Memory port.**
  - mem_req_o = |gnt_o.
  - mem_we_o, mem_addr_o and mem_wdata_o are muxed from the winner.
  - With no grant, all three are 0.
- **Read tag pipeline.**
  - RD_LAT stages of {valid, IDX_W tag}.
  - Stage 0 loads {1, winner} for a granted read, and {0, 0} otherwise. Stages shift every cycle.
- **Return.**
  - If mem_rvalid_i = 1 and the final stage is valid: rvalid_o[tag] = 1, and rdata_o = mem_rdata_i combinationally.
  - If mem_rvalid_i = 1 and the final stage is invalid: rvalid_o = 0, the data is dropped, and rsp_err_o pulses the next cycle.
  - If the final stage is valid and mem_rvalid_i = 0: rsp_err_o pulses the next cycle, and the tag is discarded.
- **Simultaneous events.** A read return and a new grant in the same cycle are independent; the memory is pipelined.
- **Reset.**
  - ptr = 0, slot = 0, all tag stages cleared, rsp_err_o = 0.
  - Combinational outputs follow from cleared state and inputs.
  - Reads in flight at reset are forgotten. Any late mem_rvalid_i after reset raises rsp_err_o.

## Timing
- Grant latency is 0 cycles: gnt_o is a combinational function of req_i, ptr and slot.
- Memory strobe latency is 0 cycles: the memory samples mem_* at the edge ending the grant cycle.
- A read granted in cycle t returns rvalid_o in cycle t+RD_LAT.
- rsp_err_o is registered and asserts one cycle after the mismatch.
- Throughput is one access per cycle in round-robin mode. In TDM mode each port is limited to 1/N.
- Registered state is limited to ptr, slot, the tag pipeline and rsp_err_o.

## Test plan
- **Single requester.** N=4; port 2 requests a write every cycle for 5 cycles → gnt_o = 4'b0100 in all 5 cycles; mem_we_o = 1; mem_addr_o tracks addr_i[2].
- **Full load, round robin.** All 4 ports hold req_i from reset → grant order 0,1,2,3,0,1,… one per cycle; gnt_idx_o sequence 0,1,2,3,0.
- **Non-power-of-two wrap.** N=3; ports 0 and 2 request → grants 0,2,0,2; ptr never holds 3; port 1 asserts later and is granted within 3 cycles.
- **TDM idle slots.** TDM=1, N=4; only port 1 requests continuously → grants in cycles 1,5,9 only; mem_req_o = 0 elsewhere.
- **Read routing.** RD_LAT=3; reads granted to ports 3,0,2 in consecutive cycles; memory returns 0xA,0xB,0xC three cycles later → rvalid_o = 8,1,4 with matching rdata_o; rsp_err_o stays 0.
- **Error and reset.**
  - Inject mem_rvalid_i with no read outstanding → rsp_err_o = 1 for exactly one cycle and rvalid_o = 0.
  - Assert rst_n low with two reads in flight, then release → no rvalid_o appears for those reads.
